// File: rtl/register_file_scoreboard.sv
// 2**ADDR_W x DATA_W register file (1W/2R) with a per-register pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data onto the read ports.
module register_file_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Reg_Write_i,
  input  logic [ADDR_W-1:0] Write_Register_i,
  input  logic [DATA_W-1:0] Write_Data_i,
  input  logic [ADDR_W-1:0] Read_Register_1_i,
  input  logic [ADDR_W-1:0] Read_Register_2_i,
  output logic [DATA_W-1:0] Read_Data_1_o,
  output logic [DATA_W-1:0] Read_Data_2_o,
  output logic              Read_Busy_1_o,
  output logic              Read_Busy_2_o,
  input  logic              Reserve_i,
  input  logic [ADDR_W-1:0] Reserve_Register_i,
  output logic              Reserve_Ready_o,
  input  logic              Flush_i,
  output logic [ADDR_W:0]   Pending_Count_o
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_en, res_zero, res_acc;

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
    logic [ADDR_W:0] n;
    n = '0;
    for (int i = 0; i < NREGS; i++) n = n + {{ADDR_W{1'b0}}, v[i]};
    return n;
  endfunction

  // Reading {busy, data} for one port; reset and the hardwired zero register both read as 0.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0] r;
    r = {pend_q[addr], mem_q[addr]};
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (Write_Register_i == addr))
      r = {res_acc && !res_zero && (Reserve_Register_i == addr), Write_Data_i};
`endif
    if (reset || is_zero(addr)) r = '0;
    return r;
  endfunction

  always_comb begin
    res_zero = is_zero(Reserve_Register_i);
    res_acc  = Reserve_i & (res_zero | (~pend_q[Reserve_Register_i] & ~Flush_i));
    wr_en    = Reg_Write_i & ~is_zero(Write_Register_i);
    pend_d   = pend_q;
    // Set after clear so a new owner wins over the retiring writer; flush overrides both.
    if (Flush_i) begin
      pend_d = '0;
    end else begin
      if (wr_en) pend_d[Write_Register_i] = 1'b0;
      if (res_acc && !res_zero) pend_d[Reserve_Register_i] = 1'b1;
    end
    cnt_d = popcount(pend_d);
  end

  always_comb begin
    {Read_Busy_1_o, Read_Data_1_o} = read_port(Read_Register_1_i);
    {Read_Busy_2_o, Read_Data_2_o} = read_port(Read_Register_2_i);
  end

  assign Reserve_Ready_o = res_acc;
  assign Pending_Count_o = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[Write_Register_i] <= Write_Data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Randomised + directed bench for register_file_scoreboard, checked every cycle against
// an array-based model of the register file and scoreboard.
module tb_register_file_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] wa = '0;
  logic [DATA_W-1:0] wd = '0;
  logic [ADDR_W-1:0] ra1 = '0, ra2 = '0;
  logic [DATA_W-1:0] rd1, rd2;
  logic              bz1, bz2;
  logic              rsv = 1'b0;
  logic [ADDR_W-1:0] rsa = '0;
  logic              rdy;
  logic              flush = 1'b0;
  logic [ADDR_W:0]   cnt;

  int checks = 0;
  int errors = 0;

  register_file_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
    .Read_Register_1_i(ra1), .Read_Register_2_i(ra2),
    .Read_Data_1_o(rd1), .Read_Data_2_o(rd2),
    .Read_Busy_1_o(bz1), .Read_Busy_2_o(bz2),
    .Reserve_i(rsv), .Reserve_Register_i(rsa), .Reserve_Ready_o(rdy),
    .Flush_i(flush), .Pending_Count_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: plain arrays, register 0 hardwired to zero.
  logic [DATA_W-1:0] m_mem [NREGS] = '{default: '0};
  bit                m_pend [NREGS] = '{default: 1'b0};
  int                m_cnt = 0;

  function automatic bit m_accept();
    return rsv && ((rsa == 0) || (!m_pend[rsa] && !flush));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
    end else begin
      bit acc;
      acc = m_accept();
      if (we && wa != 0) m_mem[wa] = wd;
      if (flush) begin
        for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
      end else begin
        if (we) m_pend[wa] = 1'b0;
        if (acc && rsa != 0) m_pend[rsa] = 1'b1;
      end
    end
    m_cnt = 0;
    for (int i = 0; i < NREGS; i++) m_cnt += int'(m_pend[i]);
  end

  function automatic logic [DATA_W:0] m_read(input logic [ADDR_W-1:0] a);
    if (reset || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == a) return {m_accept() && rsa == a, wd};
`endif
    return {m_pend[a], m_mem[a]};
  endfunction

  always @(negedge clk) begin
    logic [DATA_W:0] e1, e2;
    e1 = m_read(ra1);
    e2 = m_read(ra2);
    chk("rd1", 64'(rd1), 64'(e1[DATA_W-1:0]));
    chk("rd2", 64'(rd2), 64'(e2[DATA_W-1:0]));
    chk("busy1", 64'(bz1), 64'(e1[DATA_W]));
    chk("busy2", 64'(bz2), 64'(e2[DATA_W]));
    chk("ready", 64'(rdy), 64'(m_accept()));
    chk("count", 64'(cnt), 64'(m_cnt));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; rsv = 1'b0; flush = 1'b0;
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;

    // Every address reads zero and idle after reset.
    for (int a = 0; a < NREGS; a++) begin
      ra1 = ADDR_W'(a); ra2 = ADDR_W'(NREGS - 1 - a);
      settle();
      chk("rst_rd1", 64'(rd1), 64'h0);
      chk("rst_rd2", 64'(rd2), 64'h0);
      chk("rst_busy", 64'({bz1, bz2}), 64'h0);
      chk("rst_cnt", 64'(cnt), 64'h0);
      tick();
    end

    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; tick();
    idle(); ra1 = 5'd5; ra2 = 5'd5; settle();
    chk("r5_p1", 64'(rd1), 64'hDEADBEEF);
    chk("r5_p2", 64'(rd2), 64'hDEADBEEF);
    tick();
    we = 1'b1; wa = 5'd0; wd = 32'h1234; tick();
    idle(); ra1 = 5'd0; settle();
    chk("r0_zero", 64'(rd1), 64'h0);
    tick();

    rsv = 1'b1; rsa = 5'd7; settle();
    chk("rsv7_ready", 64'(rdy), 64'h1);
    tick();
    ra1 = 5'd7; settle();
    chk("rsv7_busy", 64'(bz1), 64'h1);
    chk("rsv7_cnt", 64'(cnt), 64'h1);
    chk("rsv7_again", 64'(rdy), 64'h0);
    tick();
    idle(); settle();
    chk("rsv7_cnt_hold", 64'(cnt), 64'h1);
    we = 1'b1; wa = 5'd7; wd = 32'hA5; tick();
    idle(); settle();
    chk("wr7_busy", 64'(bz1), 64'h0);
    chk("wr7_cnt", 64'(cnt), 64'h0);
    chk("wr7_data", 64'(rd1), 64'hA5);
    tick();

    rsv = 1'b1; rsa = 5'd9; tick();
    we = 1'b1; wa = 5'd9; wd = 32'h99; ra1 = 5'd9; settle();
    chk("waw9_ready", 64'(rdy), 64'h0);
    tick();
    we = 1'b1; wa = 5'd10; wd = 32'hAB; rsv = 1'b1; rsa = 5'd10; ra2 = 5'd10; settle();
    chk("wr_rsv10_ready", 64'(rdy), 64'h1);
    tick();
    idle(); settle();
    chk("wr_rsv10_data", 64'(rd2), 64'hAB);
    chk("wr_rsv10_busy", 64'(bz2), 64'h1);
    chk("r9_data", 64'(rd1), 64'h99);
    rsv = 1'b1; rsa = 5'd3; flush = 1'b1; settle();
    chk("flush_ready", 64'(rdy), 64'h0);
    tick();
    idle(); settle();
    chk("flush_cnt", 64'(cnt), 64'h0);
    tick();

    we = 1'b1; wa = 5'd12; wd = 32'h1111; tick();
    wd = 32'h55AA; ra1 = 5'd12; settle();
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", 64'(rd1), 64'h55AA);
`else
    chk("nobyp_data", 64'(rd1), 64'h1111);
`endif
    chk("byp_busy", 64'(bz1), 64'h0);
    tick();
    idle(); settle();
    chk("r12_next", 64'(rd1), 64'h55AA);
    tick();

    for (int r = 1; r <= 4; r++) begin
      rsv = 1'b1; rsa = ADDR_W'(r); tick();
    end
    idle(); ra1 = 5'd1; ra2 = 5'd4; settle();
    chk("rsv14_busy", 64'({bz1, bz2}), 64'h3);
    chk("rsv14_cnt", 64'(cnt), 64'h4);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'({bz1, bz2}), 64'h0);
    chk("arst_cnt", 64'(cnt), 64'h0);
    ra1 = 5'd5; #1;
    chk("arst_data", 64'(rd1), 64'h0);
    tick();
    reset = 1'b0;
    we = 1'b1; wa = 5'd2; wd = 32'h77; rsv = 1'b1; rsa = 5'd1; tick();
    idle(); ra1 = 5'd2; ra2 = 5'd1; settle();
    chk("resume_data", 64'(rd1), 64'h77);
    chk("resume_busy", 64'(bz2), 64'h1);
    chk("resume_cnt", 64'(cnt), 64'h1);
    tick();

    for (int n = 0; n < 3000; n++) begin
      we    = ($urandom % 3) == 0;
      wa    = ADDR_W'($urandom % 16);
      wd    = $urandom;
      rsv   = ($urandom % 2) == 0;
      rsa   = ADDR_W'($urandom % 16);
      flush = ($urandom % 40) == 0;
      ra1   = (($urandom % 4) == 0) ? wa : ADDR_W'($urandom % 16);
      ra2   = (($urandom % 4) == 0) ? rsa : ADDR_W'($urandom);
      tick();
    end
    idle();
    settle();
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
